fifo_write_arbiter: RTL and testbench

Round-robin write-port arbiter for the FIFO. It shares the FIFO's single write port (`write_en`, `data_in`, `full`) between NREQ producers in the write clock domain. It grants one producer at a time for a bounded burst and stalls cleanly while the FIFO reports full. It sits directly in front of the FIFO write side; the read side is untouched.

---
 rtl/fifo_write_arbiter_if.sv | 24 ++
 rtl/fifo_write_arbiter.sv | 121 ++++++++++++
 tb/tb_fifo_write_arbiter.sv | 162 ++++++++++++++++
 3 files changed

// File: rtl/fifo_write_arbiter_if.sv
// Producer/FIFO-side bundle for fifo_write_arbiter: requests and data in, grant and FIFO write out.
interface fifo_write_arbiter_if #(
  parameter int unsigned NREQ   = 4,
  parameter int unsigned DATA_W = 8
);
  logic [NREQ-1:0]        req;
  logic [NREQ*DATA_W-1:0] req_data;
  logic                   full;
  logic [NREQ-1:0]        ack;
  logic [NREQ-1:0]        grant;
  logic                   write_en;
  logic [DATA_W-1:0]      data_in;
  logic                   busy;

  modport master (
    output req, req_data, full,
    input  ack, grant, write_en, data_in, busy
  );

  modport slave (
    input  req, req_data, full,
    output ack, grant, write_en, data_in, busy
  );
endinterface

// File: rtl/fifo_write_arbiter.sv
// Round-robin burst arbiter sharing one FIFO write port among NREQ producers.
// Optional FIFO_WARB_PRIO0_EN: producer 0 wins every arbitration point.
module fifo_write_arbiter #(
  parameter int unsigned NREQ      = 4,
  parameter int unsigned DATA_W    = 8,
  parameter int unsigned BURST_MAX = 4
) (
  input  logic                 write_clk,
  input  logic                 reset,
  fifo_write_arbiter_if.slave  bus
);

  localparam int unsigned OW = (NREQ > 1) ? $clog2(NREQ) : 1;
  localparam int unsigned CW = $clog2(BURST_MAX + 1);

`ifdef FIFO_WARB_PRIO0_EN
  localparam bit PRIO0 = 1'b1;
`else
  localparam bit PRIO0 = 1'b0;
`endif

  typedef enum logic {IDLE, BURST} state_t;

  state_t            state_q, state_d;
  logic [OW-1:0]     owner_q, owner_d;
  logic [OW-1:0]     last_q, last_d;
  logic [CW-1:0]     cnt_q, cnt_d;
  logic [NREQ-1:0]   grant_q;
  logic              busy_q;

  logic              write_en_c;
  logic [NREQ-1:0]   ack_c;
  logic [DATA_W-1:0] data_c;
  logic [OW:0]       hit;
  logic              upd_last;

  // Returns {found, index}; scans base+1 upward, base itself last.
  function automatic logic [OW:0] pick(input logic [NREQ-1:0] r, input logic [OW-1:0] base);
    logic [OW:0] res;
    res = '0;
    for (int unsigned k = NREQ; k >= 1; k--) begin
      if (r[OW'((32'(base) + k) % NREQ)]) res = {1'b1, OW'((32'(base) + k) % NREQ)};
    end
    if (PRIO0 && r[0]) res = {1'b1, OW'(0)};
    return res;
  endfunction

  assign upd_last = !PRIO0 || (owner_q != '0);

  // Next-state and combinational write-side outputs
  always_comb begin
    state_d    = state_q;
    owner_d    = owner_q;
    last_d     = last_q;
    cnt_d      = cnt_q;
    write_en_c = 1'b0;
    ack_c      = '0;
    data_c     = '0;
    hit        = '0;

    case (state_q)
      IDLE: begin
        hit = pick(bus.req, last_q);
        if (hit[OW]) begin
          state_d = BURST;
          owner_d = hit[OW-1:0];
          cnt_d   = '0;
        end
      end

      BURST: begin
        data_c = bus.req_data[owner_q*DATA_W +: DATA_W];
        if (!bus.req[owner_q]) begin
          state_d = IDLE;
          if (upd_last) last_d = owner_q;
        end else if (!bus.full) begin
          // A beat in the reset cycle would be a partial write the FIFO keeps.
          write_en_c     = !reset;
          ack_c[owner_q] = !reset;
          if (cnt_q == CW'(BURST_MAX - 1)) begin
            if (upd_last) last_d = owner_q;
            hit   = pick(bus.req, owner_q);
            cnt_d = '0;
            if (hit[OW]) owner_d = hit[OW-1:0];
            else         state_d = IDLE;
          end else begin
            cnt_d = cnt_q + CW'(1);
          end
        end
      end

      default: state_d = IDLE;
    endcase
  end

  // State, arbitration history and registered grant/busy
  always_ff @(posedge write_clk) begin
    if (reset) begin
      state_q <= IDLE;
      owner_q <= '0;
      last_q  <= OW'(NREQ - 1);
      cnt_q   <= '0;
      grant_q <= '0;
      busy_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      owner_q <= owner_d;
      last_q  <= last_d;
      cnt_q   <= cnt_d;
      grant_q <= (state_d == BURST) ? (NREQ'(1) << owner_d) : '0;
      busy_q  <= (state_d == BURST);
    end
  end

  assign bus.write_en = write_en_c;
  assign bus.ack      = ack_c;
  assign bus.data_in  = data_c;
  assign bus.grant    = grant_q;
  assign bus.busy     = busy_q;

endmodule

// File: tb/tb_fifo_write_arbiter.sv
// Directed vector bench for fifo_write_arbiter (NREQ=4, DATA_W=8, BURST_MAX=4).
module tb_fifo_write_arbiter;

  localparam int unsigned NREQ      = 4;
  localparam int unsigned DATA_W    = 8;
  localparam int unsigned BURST_MAX = 4;
  localparam int unsigned NVEC      = 39;
  // Producer 3..0 data bytes.
  localparam logic [31:0] PDATA = 32'h44_33_A5_11;

`ifdef FIFO_WARB_PRIO0_EN
  localparam bit          PRIO0   = 1'b1;
  localparam logic [3:0]  G_AFTER = 4'b0001;
  localparam logic [7:0]  D_AFTER = 8'h11;
`else
  localparam bit          PRIO0   = 1'b0;
  localparam logic [3:0]  G_AFTER = 4'b0010;
  localparam logic [7:0]  D_AFTER = 8'hA5;
`endif

  typedef struct packed {
    logic       rst;
    logic [3:0] req;
    logic       full;
    logic [3:0] g;
    logic       b;
    logic       we;
    logic [3:0] ack;
    logic [7:0] d;
  } vec_t;

  logic write_clk = 1'b0;
  logic reset;
  int   n_cmp = 0;
  int   n_err = 0;
  vec_t tbl [NVEC];

  always #5 write_clk = ~write_clk;

  fifo_write_arbiter_if #(.NREQ(NREQ), .DATA_W(DATA_W)) bus ();

  fifo_write_arbiter #(.NREQ(NREQ), .DATA_W(DATA_W), .BURST_MAX(BURST_MAX)) dut (
    .write_clk (write_clk),
    .reset     (reset),
    .bus       (bus)
  );

  function automatic vec_t mk(input logic rst, input logic [3:0] req, input logic full,
                              input logic [3:0] g, input logic b, input logic we,
                              input logic [3:0] ack, input logic [7:0] d);
    vec_t v;
    v = '{rst, req, full, g, b, we, ack, d};
    return v;
  endfunction

  function automatic logic [7:0] pbyte(input int o);
    logic [31:0] v;
    v = PDATA;
    return v[o*8 +: 8];
  endfunction

  task automatic chk(input string nm, input int idx, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s[%0d]: got %h expected %h", nm, idx, act, exp);
    end
  endtask

  task automatic chk_all(input string tag, input int idx, input logic [3:0] g, input logic b,
                         input logic we, input logic [3:0] ack, input logic [7:0] d);
    chk({tag, ".grant"},    idx, 32'(bus.grant),    32'(g));
    chk({tag, ".busy"},     idx, 32'(bus.busy),     32'(b));
    chk({tag, ".write_en"}, idx, 32'(bus.write_en), 32'(we));
    chk({tag, ".ack"},      idx, 32'(bus.ack),      32'(ack));
    chk({tag, ".data_in"},  idx, 32'(bus.data_in),  32'(d));
  endtask

  initial begin
    int o;
    logic [3:0] eg;

    reset        = 1'b1;
    bus.req      = '0;
    bus.req_data = PDATA;
    bus.full     = 1'b0;

    // Reset, first grant, release
    tbl[0]  = mk(1, 4'b1111, 0, 4'b0000, 0, 0, 4'b0000, 8'h00);
    tbl[1]  = mk(1, 4'b1111, 0, 4'b0000, 0, 0, 4'b0000, 8'h00);
    tbl[2]  = mk(0, 4'b1111, 0, 4'b0000, 0, 0, 4'b0000, 8'h00);
    tbl[3]  = mk(0, 4'b0000, 0, 4'b0001, 1, 0, 4'b0000, 8'h11);
    // Single producer: two back-to-back bursts
    tbl[4]  = mk(0, 4'b0010, 0, 4'b0000, 0, 0, 4'b0000, 8'h00);
    for (int i = 5; i <= 12; i++) tbl[i] = mk(0, 4'b0010, 0, 4'b0010, 1, 1, 4'b0010, 8'hA5);
    tbl[13] = mk(0, 4'b0000, 0, 4'b0010, 1, 0, 4'b0000, 8'hA5);
    tbl[14] = mk(0, 4'b0000, 0, 4'b0000, 0, 0, 4'b0000, 8'h00);
    // Full stall on owner 2 after two beats
    tbl[15] = mk(0, 4'b0100, 0, 4'b0000, 0, 0, 4'b0000, 8'h00);
    tbl[16] = mk(0, 4'b0100, 0, 4'b0100, 1, 1, 4'b0100, 8'h33);
    tbl[17] = mk(0, 4'b0100, 0, 4'b0100, 1, 1, 4'b0100, 8'h33);
    for (int i = 18; i <= 20; i++) tbl[i] = mk(0, 4'b0100, 1, 4'b0100, 1, 0, 4'b0000, 8'h33);
    tbl[21] = mk(0, 4'b0100, 0, 4'b0100, 1, 1, 4'b0100, 8'h33);
    tbl[22] = mk(0, 4'b0101, 0, 4'b0100, 1, 1, 4'b0100, 8'h33);
    // Rotation to 0, then early release with req[2] waiting
    tbl[23] = mk(0, 4'b0101, 0, 4'b0001, 1, 1, 4'b0001, 8'h11);
    tbl[24] = mk(0, 4'b0100, 0, 4'b0001, 1, 0, 4'b0000, 8'h11);
    tbl[25] = mk(0, 4'b0100, 0, 4'b0000, 0, 0, 4'b0000, 8'h00);
    tbl[26] = mk(0, 4'b0100, 0, 4'b0100, 1, 1, 4'b0100, 8'h33);
    tbl[27] = mk(0, 4'b0000, 0, 4'b0100, 1, 0, 4'b0000, 8'h33);
    // Reset during beat 3 of owner 1
    tbl[28] = mk(0, 4'b0010, 0, 4'b0000, 0, 0, 4'b0000, 8'h00);
    tbl[29] = mk(0, 4'b0010, 0, 4'b0010, 1, 1, 4'b0010, 8'hA5);
    tbl[30] = mk(0, 4'b0010, 0, 4'b0010, 1, 1, 4'b0010, 8'hA5);
    tbl[31] = mk(1, 4'b0010, 0, 4'b0010, 1, 0, 4'b0000, 8'hA5);
    tbl[32] = mk(0, 4'b0011, 0, 4'b0000, 0, 0, 4'b0000, 8'h00);
    for (int i = 33; i <= 36; i++) tbl[i] = mk(0, 4'b0011, 0, 4'b0001, 1, 1, 4'b0001, 8'h11);
    tbl[37] = mk(0, 4'b0011, 0, G_AFTER, 1, 1, G_AFTER, D_AFTER);
    tbl[38] = mk(0, 4'b0000, 0, G_AFTER, 1, 0, 4'b0000, D_AFTER);

    for (int i = 0; i < int'(NVEC); i++) begin
      @(posedge write_clk);
      #1;
      reset    = tbl[i].rst;
      bus.req  = tbl[i].req;
      bus.full = tbl[i].full;
      @(negedge write_clk);
      chk_all("vec", i, tbl[i].g, tbl[i].b, tbl[i].we, tbl[i].ack, tbl[i].d);
    end

    // Continuous requests from all producers: rotation with no bubble
    @(posedge write_clk);
    #1;
    reset   = 1'b1;
    bus.req = 4'b0000;
    @(posedge write_clk);
    #1;
    reset   = 1'b0;
    bus.req = 4'b1111;
    @(negedge write_clk);
    chk_all("rr_idle", 0, 4'b0000, 0, 0, 4'b0000, 8'h00);
    for (int k = 0; k < 20; k++) begin
      @(posedge write_clk);
      #1;
      @(negedge write_clk);
      o  = PRIO0 ? 0 : (k / 4) % 4;
      eg = 4'b0001 << o;
      chk_all("rr", k, eg, 1, 1, eg, pbyte(o));
    end
    @(posedge write_clk);
    #1;
    bus.req = 4'b0000;
    @(posedge write_clk);
    #1;
    @(negedge write_clk);
    chk_all("rr_done", 0, 4'b0000, 0, 0, 4'b0000, 8'h00);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
